mbinit_reversalmb_ctrl: RTL and testbench

Initiator-side controller for the MBINIT.REVERSALMB step: runs the sideband handshake, triggers the per-lane ID pattern, evaluates the partner's lane result, applies lane reversal once if needed, and signals completion. It sits directly upstream of the REPAIRMB stage. Its `o_MBINIT_REVERSALMB_end` is the `MBINIT_REVERSALMB_end` start input of the REPAIRMB wrapper. It shares the sideband TX mux and busy signalling with the other MBINIT stages.

---
 rtl/mbinit_reversalmb_pkg.sv | 43 ++++
 rtl/lane_pass_popcount.sv | 18 +
 rtl/mbinit_reversalmb_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mbinit_reversalmb_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbinit_reversalmb_pkg.sv
// Shared definitions for the MBINIT.REVERSALMB initiator: FSM state encoding and
// the sideband message codes (also used by the responder-side block).
package mbinit_reversalmb_pkg;

  localparam logic [3:0] MSG_NONE        = 4'd0;
  localparam logic [3:0] MSG_INIT_REQ    = 4'd1;
  localparam logic [3:0] MSG_INIT_RESP   = 4'd2;
  localparam logic [3:0] MSG_CLR_REQ     = 4'd3;
  localparam logic [3:0] MSG_CLR_RESP    = 4'd4;
  localparam logic [3:0] MSG_RESULT_REQ  = 4'd5;
  localparam logic [3:0] MSG_RESULT_RESP = 4'd6;
  localparam logic [3:0] MSG_DONE_REQ    = 4'd7;
  localparam logic [3:0] MSG_DONE_RESP   = 4'd8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SEND_INIT,
    ST_WAIT_INIT,
    ST_SEND_CLR,
    ST_WAIT_CLR,
    ST_PATTERN,
    ST_SEND_RESULT,
    ST_WAIT_RESULT,
    ST_EVAL,
    ST_APPLY_REV,
    ST_SEND_DONE,
    ST_WAIT_DONE,
    ST_DONE,
    ST_ERROR
  } state_t;

  // Request code driven while in a SEND state; MSG_NONE everywhere else.
  function automatic logic [3:0] req_code(input state_t st);
    case (st)
      ST_SEND_INIT:   return MSG_INIT_REQ;
      ST_SEND_CLR:    return MSG_CLR_REQ;
      ST_SEND_RESULT: return MSG_RESULT_REQ;
      ST_SEND_DONE:   return MSG_DONE_REQ;
      default:        return MSG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/lane_pass_popcount.sv
// Combinational count of passing lanes in the captured partner result.
module lane_pass_popcount #(
  parameter int LANES = 16
) (
  input  logic [LANES-1:0]             lanes,
  output logic [$clog2(LANES+1)-1:0]   count
);

  localparam int CW = $clog2(LANES + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < LANES; i++) begin
      count = count + CW'(lanes[i]);
    end
  end

endmodule

// File: rtl/mbinit_reversalmb_ctrl.sv
// MBINIT.REVERSALMB initiator controller: sideband handshake, lane-ID pattern,
// result evaluation with a single lane-reversal retry. REVERSALMB_TIMEOUT_EN adds wait timeouts.
module mbinit_reversalmb_ctrl
  import mbinit_reversalmb_pkg::*;
#(
  parameter int LANES          = 16,
  parameter int TIMEOUT_CYCLES = 8000
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             i_MBINIT_REPAIRVAL_end,
  input  logic [3:0]       i_RX_SbMessage,
  input  logic             i_msg_valid,
  input  logic [LANES-1:0] i_RX_lane_result,
  input  logic             i_falling_edge_busy,
  input  logic             i_pattern_done,
  output logic [3:0]       o_TX_SbMessage,
  output logic             o_ValidOutDatat_REVERSALMB,
  output logic             o_pattern_en,
  output logic             o_reversal_en,
  output logic             o_MBINIT_REVERSALMB_end,
  output logic             o_train_error
);

  localparam int CW = $clog2(LANES + 1);
  localparam logic [CW-1:0] PASS_HALF = CW'(LANES / 2);

  state_t           state_reg, state_next;
  logic [LANES-1:0] result_reg;
  logic [CW-1:0]    pass_count;
  logic             timeout_hit;

  logic [3:0] tx_msg_reg, tx_msg_next;
  logic       valid_reg, valid_next;
  logic       pattern_en_reg, pattern_en_next;
  logic       reversal_en_reg, reversal_en_next;
  logic       end_reg, end_next;
  logic       train_error_reg, train_error_next;

  lane_pass_popcount #(.LANES(LANES)) u_popcount (
    .lanes (result_reg),
    .count (pass_count)
  );

`ifdef REVERSALMB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_reg;
  logic          tmo_active;

  assign tmo_active = (state_reg == ST_WAIT_INIT)   || (state_reg == ST_WAIT_CLR) ||
                      (state_reg == ST_WAIT_RESULT) || (state_reg == ST_WAIT_DONE) ||
                      (state_reg == ST_PATTERN);
  assign timeout_hit = tmo_active && (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 1));

  // Counts cycles spent in the current state; any state change restarts it.
  always_ff @(posedge CLK) begin
    if (rst || (state_next != state_reg)) begin
      tmo_cnt_reg <= '0;
    end else if (tmo_active) begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  // State and registered outputs
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      result_reg      <= '0;
      tx_msg_reg      <= MSG_NONE;
      valid_reg       <= 1'b0;
      pattern_en_reg  <= 1'b0;
      reversal_en_reg <= 1'b0;
      end_reg         <= 1'b0;
      train_error_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      tx_msg_reg      <= tx_msg_next;
      valid_reg       <= valid_next;
      pattern_en_reg  <= pattern_en_next;
      reversal_en_reg <= reversal_en_next;
      end_reg         <= end_next;
      train_error_reg <= train_error_next;
      if ((state_reg == ST_WAIT_RESULT) && i_msg_valid &&
          (i_RX_SbMessage == MSG_RESULT_RESP)) begin
        result_reg <= i_RX_lane_result;
      end
    end
  end

  // Next-state logic; losing the start level aborts from anywhere.
  always_comb begin
    state_next = state_reg;
    if ((state_reg != ST_IDLE) && !i_MBINIT_REPAIRVAL_end) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:        if (i_MBINIT_REPAIRVAL_end) state_next = ST_SEND_INIT;
        ST_SEND_INIT:   if (i_falling_edge_busy) state_next = ST_WAIT_INIT;
        ST_WAIT_INIT: begin
          if (i_msg_valid && (i_RX_SbMessage == MSG_INIT_RESP)) state_next = ST_SEND_CLR;
          else if (timeout_hit)                                 state_next = ST_ERROR;
        end
        ST_SEND_CLR:    if (i_falling_edge_busy) state_next = ST_WAIT_CLR;
        ST_WAIT_CLR: begin
          if (i_msg_valid && (i_RX_SbMessage == MSG_CLR_RESP)) state_next = ST_PATTERN;
          else if (timeout_hit)                                state_next = ST_ERROR;
        end
        ST_PATTERN: begin
          if (i_pattern_done)   state_next = ST_SEND_RESULT;
          else if (timeout_hit) state_next = ST_ERROR;
        end
        ST_SEND_RESULT: if (i_falling_edge_busy) state_next = ST_WAIT_RESULT;
        ST_WAIT_RESULT: begin
          if (i_msg_valid && (i_RX_SbMessage == MSG_RESULT_RESP)) state_next = ST_EVAL;
          else if (timeout_hit)                                   state_next = ST_ERROR;
        end
        ST_EVAL: begin
          if (pass_count > PASS_HALF) state_next = ST_SEND_DONE;
          else if (!reversal_en_reg)  state_next = ST_APPLY_REV;
          else                        state_next = ST_ERROR;
        end
        ST_APPLY_REV:   state_next = ST_SEND_CLR;
        ST_SEND_DONE:   if (i_falling_edge_busy) state_next = ST_WAIT_DONE;
        ST_WAIT_DONE: begin
          if (i_msg_valid && (i_RX_SbMessage == MSG_DONE_RESP)) state_next = ST_DONE;
          else if (timeout_hit)                                 state_next = ST_ERROR;
        end
        ST_DONE:        state_next = ST_DONE;
        ST_ERROR:       state_next = ST_ERROR;
        default:        state_next = ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from the upcoming state so they register in step with it.
  always_comb begin
    tx_msg_next      = req_code(state_next);
    valid_next       = (req_code(state_next) != MSG_NONE);
    pattern_en_next  = (state_next == ST_PATTERN);
    end_next         = (state_next == ST_DONE);
    train_error_next = (state_next == ST_ERROR);
    reversal_en_next = reversal_en_reg;
    if (state_next == ST_IDLE) begin
      reversal_en_next = 1'b0;
    end else if (state_next == ST_APPLY_REV) begin
      reversal_en_next = 1'b1;
    end
  end

  assign o_TX_SbMessage             = tx_msg_reg;
  assign o_ValidOutDatat_REVERSALMB = valid_reg;
  assign o_pattern_en               = pattern_en_reg;
  assign o_reversal_en              = reversal_en_reg;
  assign o_MBINIT_REVERSALMB_end    = end_reg;
  assign o_train_error              = train_error_reg;

endmodule

// File: tb/tb_mbinit_reversalmb_ctrl.sv
// Directed bench for mbinit_reversalmb_ctrl; output vector is {tx[3:0], valid, pattern_en,
// reversal_en, end, train_error}. Timeout scenario follows REVERSALMB_TIMEOUT_EN.
module tb_mbinit_reversalmb_ctrl;

  logic        CLK = 1'b0;
  logic        rst;
  logic        i_MBINIT_REPAIRVAL_end;
  logic [3:0]  i_RX_SbMessage;
  logic        i_msg_valid;
  logic [15:0] i_RX_lane_result;
  logic        i_falling_edge_busy;
  logic        i_pattern_done;
  logic [3:0]  o_TX_SbMessage;
  logic        o_ValidOutDatat_REVERSALMB;
  logic        o_pattern_en;
  logic        o_reversal_en;
  logic        o_MBINIT_REVERSALMB_end;
  logic        o_train_error;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  mbinit_reversalmb_ctrl #(.LANES(16), .TIMEOUT_CYCLES(16)) dut (
    .CLK                        (CLK),
    .rst                        (rst),
    .i_MBINIT_REPAIRVAL_end     (i_MBINIT_REPAIRVAL_end),
    .i_RX_SbMessage             (i_RX_SbMessage),
    .i_msg_valid                (i_msg_valid),
    .i_RX_lane_result           (i_RX_lane_result),
    .i_falling_edge_busy        (i_falling_edge_busy),
    .i_pattern_done             (i_pattern_done),
    .o_TX_SbMessage             (o_TX_SbMessage),
    .o_ValidOutDatat_REVERSALMB (o_ValidOutDatat_REVERSALMB),
    .o_pattern_en               (o_pattern_en),
    .o_reversal_en              (o_reversal_en),
    .o_MBINIT_REVERSALMB_end    (o_MBINIT_REVERSALMB_end),
    .o_train_error              (o_train_error)
  );

  function automatic logic [8:0] outs();
    return {o_TX_SbMessage, o_ValidOutDatat_REVERSALMB, o_pattern_en,
            o_reversal_en, o_MBINIT_REVERSALMB_end, o_train_error};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_busy();
    i_falling_edge_busy = 1'b1;
    tick();
    i_falling_edge_busy = 1'b0;
  endtask

  task automatic pulse_pattern();
    i_pattern_done = 1'b1;
    tick();
    i_pattern_done = 1'b0;
  endtask

  task automatic send_rx(input logic [3:0] code, input logic [15:0] res);
    i_RX_SbMessage   = code;
    i_RX_lane_result = res;
    i_msg_valid      = 1'b1;
    tick();
    i_msg_valid      = 1'b0;
    i_RX_SbMessage   = 4'd0;
    i_RX_lane_result = 16'h0;
  endtask

  // Start -> INIT handshake; ends in SEND_CLR.
  task automatic go_to_send_clr();
    i_MBINIT_REPAIRVAL_end = 1'b1;
    tick();
    pulse_busy();
    send_rx(4'd2, 16'h0);
  endtask

  // From SEND_CLR through one CLR/pattern/RESULT round; ends in EVAL.
  task automatic clr_round(input logic [15:0] res);
    pulse_busy();
    send_rx(4'd4, 16'h0);
    pulse_pattern();
    pulse_busy();
    send_rx(4'd6, res);
  endtask

  task automatic back_to_idle();
    i_MBINIT_REPAIRVAL_end = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_MBINIT_REPAIRVAL_end = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (outs() !== 9'h000) begin n_bad++; $display("FAIL reset_outs: got %h want 000", outs()); end
    rst = 1'b0;
    i_MBINIT_REPAIRVAL_end = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_clean_pass();
    i_MBINIT_REPAIRVAL_end = 1'b1;
    tick();
    n_cmp++;
    if (outs() !== {4'd1, 5'b10000}) begin n_bad++; $display("FAIL clean_init_req: got %h want %h", outs(), {4'd1, 5'b10000}); end
    pulse_busy();
    n_cmp++;
    if (o_ValidOutDatat_REVERSALMB !== 1'b0) begin n_bad++; $display("FAIL clean_valid_drop: got %b want 0", o_ValidOutDatat_REVERSALMB); end
    send_rx(4'd2, 16'h0);
    n_cmp++;
    if (outs() !== {4'd3, 5'b10000}) begin n_bad++; $display("FAIL clean_clr_req: got %h want %h", outs(), {4'd3, 5'b10000}); end
    pulse_busy();
    send_rx(4'd4, 16'h0);
    n_cmp++;
    if (outs() !== {4'd0, 5'b01000}) begin n_bad++; $display("FAIL clean_pattern_en: got %h want %h", outs(), {4'd0, 5'b01000}); end
    pulse_pattern();
    n_cmp++;
    if (outs() !== {4'd5, 5'b10000}) begin n_bad++; $display("FAIL clean_result_req: got %h want %h", outs(), {4'd5, 5'b10000}); end
    pulse_busy();
    send_rx(4'd6, 16'hFFFF);
    n_cmp++;
    if (outs() !== 9'h000) begin n_bad++; $display("FAIL clean_eval_quiet: got %h want 000", outs()); end
    tick();
    n_cmp++;
    if (outs() !== {4'd7, 5'b10000}) begin n_bad++; $display("FAIL clean_done_req: got %h want %h", outs(), {4'd7, 5'b10000}); end
    pulse_busy();
    send_rx(4'd8, 16'h0);
    n_cmp++;
    if (outs() !== {4'd0, 5'b00010}) begin n_bad++; $display("FAIL clean_end: got %h want %h", outs(), {4'd0, 5'b00010}); end
    back_to_idle();
    n_cmp++;
    if (outs() !== 9'h000) begin n_bad++; $display("FAIL clean_release: got %h want 000", outs()); end
    $display("test_clean_pass done");
  endtask

  task automatic test_threshold();
    go_to_send_clr();
    clr_round(16'h01FF);
    tick();
    n_cmp++;
    if (outs() !== {4'd7, 5'b10000}) begin n_bad++; $display("FAIL thresh_9_pass: got %h want %h", outs(), {4'd7, 5'b10000}); end
    back_to_idle();
    $display("test_threshold done");
  endtask

  task automatic test_reversal();
    go_to_send_clr();
    clr_round(16'h00FF);
    tick();
    n_cmp++;
    if (outs() !== {4'd0, 5'b00100}) begin n_bad++; $display("FAIL rev_apply: got %h want %h", outs(), {4'd0, 5'b00100}); end
    tick();
    n_cmp++;
    if (outs() !== {4'd3, 5'b10100}) begin n_bad++; $display("FAIL rev_clr_resend: got %h want %h", outs(), {4'd3, 5'b10100}); end
    clr_round(16'hFFFE);
    tick();
    n_cmp++;
    if (outs() !== {4'd7, 5'b10100}) begin n_bad++; $display("FAIL rev_done_req: got %h want %h", outs(), {4'd7, 5'b10100}); end
    pulse_busy();
    send_rx(4'd8, 16'h0);
    n_cmp++;
    if (outs() !== {4'd0, 5'b00110}) begin n_bad++; $display("FAIL rev_end: got %h want %h", outs(), {4'd0, 5'b00110}); end
    back_to_idle();
    n_cmp++;
    if (o_reversal_en !== 1'b0) begin n_bad++; $display("FAIL rev_cleared_idle: got %b want 0", o_reversal_en); end
    $display("test_reversal done");
  endtask

  task automatic test_double_fail();
    go_to_send_clr();
    clr_round(16'h0001);
    tick();
    tick();
    clr_round(16'h0000);
    tick();
    n_cmp++;
    if (outs() !== {4'd0, 5'b00101}) begin n_bad++; $display("FAIL dfail_error: got %h want %h", outs(), {4'd0, 5'b00101}); end
    repeat (3) tick();
    n_cmp++;
    if (outs() !== {4'd0, 5'b00101}) begin n_bad++; $display("FAIL dfail_sticky: got %h want %h", outs(), {4'd0, 5'b00101}); end
    back_to_idle();
    n_cmp++;
    if (outs() !== 9'h000) begin n_bad++; $display("FAIL dfail_release: got %h want 000", outs()); end
    $display("test_double_fail done");
  endtask

  task automatic test_unexpected();
    i_MBINIT_REPAIRVAL_end = 1'b1;
    tick();
    send_rx(4'd2, 16'h0);
    n_cmp++;
    if (outs() !== {4'd1, 5'b10000}) begin n_bad++; $display("FAIL unexp_send_ignores_rx: got %h want %h", outs(), {4'd1, 5'b10000}); end
    pulse_busy();
    send_rx(4'd8, 16'h0);
    send_rx(4'd4, 16'h0);
    n_cmp++;
    if (outs() !== 9'h000) begin n_bad++; $display("FAIL unexp_wait_init_held: got %h want 000", outs()); end
    send_rx(4'd2, 16'h0);
    n_cmp++;
    if (outs() !== {4'd3, 5'b10000}) begin n_bad++; $display("FAIL unexp_init_resp: got %h want %h", outs(), {4'd3, 5'b10000}); end
    pulse_pattern();
    n_cmp++;
    if (outs() !== {4'd3, 5'b10000}) begin n_bad++; $display("FAIL unexp_stray_pattern: got %h want %h", outs(), {4'd3, 5'b10000}); end
    back_to_idle();
    $display("test_unexpected done");
  endtask

  task automatic test_timeout();
    i_MBINIT_REPAIRVAL_end = 1'b1;
    tick();
    pulse_busy();
    repeat (15) tick();
    n_cmp++;
    if (outs() !== 9'h000) begin n_bad++; $display("FAIL tmo_before: got %h want 000", outs()); end
`ifdef REVERSALMB_TIMEOUT_EN
    tick();
    n_cmp++;
    if (outs() !== {4'd0, 5'b00001}) begin n_bad++; $display("FAIL tmo_error_at_16: got %h want %h", outs(), {4'd0, 5'b00001}); end
`else
    repeat (85) tick();
    n_cmp++;
    if (outs() !== 9'h000) begin n_bad++; $display("FAIL tmo_still_waiting: got %h want 000", outs()); end
    send_rx(4'd2, 16'h0);
    n_cmp++;
    if (outs() !== {4'd3, 5'b10000}) begin n_bad++; $display("FAIL tmo_late_resp: got %h want %h", outs(), {4'd3, 5'b10000}); end
`endif
    back_to_idle();
    $display("test_timeout done");
  endtask

  task automatic test_reset_midop();
    go_to_send_clr();
    n_cmp++;
    if (outs() !== {4'd3, 5'b10000}) begin n_bad++; $display("FAIL midrst_in_clr: got %h want %h", outs(), {4'd3, 5'b10000}); end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (outs() !== 9'h000) begin n_bad++; $display("FAIL midrst_outs: got %h want 000", outs()); end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (outs() !== {4'd1, 5'b10000}) begin n_bad++; $display("FAIL midrst_restart: got %h want %h", outs(), {4'd1, 5'b10000}); end
    back_to_idle();
    $display("test_reset_midop done");
  endtask

  task automatic test_abort();
    go_to_send_clr();
    pulse_busy();
    send_rx(4'd4, 16'h0);
    pulse_pattern();
    pulse_busy();
    i_MBINIT_REPAIRVAL_end = 1'b0;
    tick();
    n_cmp++;
    if (outs() !== 9'h000) begin n_bad++; $display("FAIL abort_outs: got %h want 000", outs()); end
    i_MBINIT_REPAIRVAL_end = 1'b1;
    tick();
    n_cmp++;
    if (outs() !== {4'd1, 5'b10000}) begin n_bad++; $display("FAIL abort_from_idle: got %h want %h", outs(), {4'd1, 5'b10000}); end
    back_to_idle();
    $display("test_abort done");
  endtask

  initial begin
    rst                    = 1'b1;
    i_MBINIT_REPAIRVAL_end = 1'b0;
    i_RX_SbMessage         = 4'd0;
    i_msg_valid            = 1'b0;
    i_RX_lane_result       = 16'h0;
    i_falling_edge_busy    = 1'b0;
    i_pattern_done         = 1'b0;
    test_reset();
    test_clean_pass();
    test_threshold();
    test_reversal();
    test_double_fail();
    test_unexpected();
    test_timeout();
    test_reset_midop();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
